// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 device port.
package ps2_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StTx,
    StRx,
    StInhibit
  } ps2_state_e;

  localparam int unsigned PS2_FRAME_BITS = 11;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Count-based byte FIFO feeding the PS/2 transmitter; sticky overflow on dropped writes.
module ps2_fifo #(
  parameter int unsigned FIFO_BITS = 3
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               push,
  input  logic [7:0]         push_data,
  input  logic               pop,
  output logic [7:0]         head,
  output logic [FIFO_BITS:0] count,
  output logic               full,
  output logic               overflow
);

  localparam int unsigned Depth = 1 << FIFO_BITS;
  localparam logic [FIFO_BITS:0] DepthCnt = {1'b1, {FIFO_BITS{1'b0}}};

  logic [7:0]           mem_q [Depth];
  logic [FIFO_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_BITS:0]   count_q;
  logic                 do_push, do_pop;

  assign count   = count_q;
  assign full    = (count_q == DepthCnt);
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && (count_q != '0);
  // A pop in the same cycle frees the slot, so a write while full is still accepted.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk_sys) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/ps2_device_port.sv
// Bidirectional PS/2 device emulator: FIFO-fed transmit frames, host command receive with ack,
// and host-inhibit abort/retry.
module ps2_device_port
  import ps2_pkg::*;
#(
  parameter int unsigned PS2DIV    = 100,
  parameter int unsigned FIFO_BITS = 3
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic [7:0] wr_data,
  input  logic       wr_strobe,
  output logic       fifo_full,
  output logic       overflow,
  output logic       ps2_clk_out,
  output logic       ps2_data_out,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic [7:0] rx_data,
  output logic       rx_strobe,
  output logic       rx_parity_err,
  output logic       busy
);

  localparam int unsigned DivW = (PS2DIV > 1) ? $clog2(PS2DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(PS2DIV - 1);
  localparam logic [3:0] LastBit = 4'(PS2_FRAME_BITS - 1);

  logic [DivW-1:0]    div_q;
  logic               phase_q, tick, rise_tick, fall_tick;
  logic [1:0]         clk_sync_q, data_sync_q;
  logic               clk_s, data_s;
  ps2_state_e         state_q;
  logic [3:0]         bit_idx_q;
  logic [9:0]         shift_q;
  logic               inh_seen_q;
  logic               fifo_pop, fifo_empty;
  logic [7:0]         fifo_head;
  logic [FIFO_BITS:0] fifo_count;

  ps2_fifo #(
    .FIFO_BITS(FIFO_BITS)
  ) u_fifo (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .push     (wr_strobe),
    .push_data(wr_data),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .count    (fifo_count),
    .full     (fifo_full),
    .overflow (overflow)
  );

  assign fifo_empty = (fifo_count == '0);
  assign tick       = (div_q == DivMax);
  // Rise ticks release the clock (and shift data); fall ticks pull it low.
  assign rise_tick  = tick & phase_q;
  assign fall_tick  = tick & ~phase_q;
  assign clk_s      = clk_sync_q[1];
  assign data_s     = data_sync_q[1];
  assign fifo_pop   = (state_q == StTx) && rise_tick && (bit_idx_q == LastBit);
  assign busy       = (state_q != StIdle);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_q       <= '0;
      phase_q     <= 1'b0;
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      div_q       <= tick ? '0 : div_q + 1'b1;
      if (tick) phase_q <= ~phase_q;
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
      data_sync_q <= {data_sync_q[0], ps2_data_in};
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= StIdle;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      inh_seen_q    <= 1'b0;
      ps2_clk_out   <= 1'b1;
      ps2_data_out  <= 1'b1;
      rx_data       <= '0;
      rx_strobe     <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      rx_strobe <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rise_tick && clk_s) begin
            bit_idx_q <= '0;
            if (!data_s) begin
              state_q <= StRx;
            end else if (!fifo_empty) begin
              shift_q      <= {1'b1, odd_parity(fifo_head), fifo_head};
              ps2_data_out <= 1'b0;
              state_q      <= StTx;
            end
          end
        end
        StTx: begin
          if (ps2_clk_out && !clk_s && bit_idx_q != LastBit) begin
            ps2_clk_out  <= 1'b1;
            ps2_data_out <= 1'b1;
            inh_seen_q   <= 1'b0;
            state_q      <= StInhibit;
          end else if (fall_tick) begin
            ps2_clk_out <= 1'b0;
          end else if (rise_tick) begin
            ps2_clk_out <= 1'b1;
            if (bit_idx_q == LastBit) begin
              ps2_data_out <= 1'b1;
              state_q      <= StIdle;
            end else begin
              bit_idx_q    <= bit_idx_q + 1'b1;
              ps2_data_out <= shift_q[0];
              shift_q      <= {1'b1, shift_q[9:1]};
            end
          end
        end
        StRx: begin
          if (ps2_clk_out && !clk_s) begin
            ps2_data_out <= 1'b1;
            inh_seen_q   <= 1'b0;
            state_q      <= StInhibit;
          end else if (fall_tick) begin
            ps2_clk_out <= 1'b0;
            if (bit_idx_q == LastBit) ps2_data_out <= 1'b0;
          end else if (rise_tick) begin
            ps2_clk_out <= 1'b1;
            if (bit_idx_q == LastBit) begin
              ps2_data_out  <= 1'b1;
              state_q       <= StIdle;
              rx_strobe     <= 1'b1;
              rx_data       <= shift_q[7:0];
              rx_parity_err <= ~(^shift_q[8:0]);
            end else begin
              shift_q   <= {data_s, shift_q[9:1]};
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end
        end
        StInhibit: begin
          if (!clk_s) begin
            inh_seen_q <= 1'b0;
          end else if (tick) begin
            if (inh_seen_q) state_q <= StIdle;
            else            inh_seen_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_device_port.sv
// Self-checking bench for ps2_device_port: TX frames scoreboarded against written bytes,
// host inhibit/retry, overflow, host-to-device receive and mid-frame reset.
module tb_ps2_device_port;
  import ps2_pkg::*;

  localparam int unsigned Div = 4;

  logic       clk_sys = 1'b0;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_strobe;
  logic       fifo_full, overflow, ps2_clk_out, ps2_data_out;
  logic       host_clk, host_data;
  logic [7:0] rx_data;
  logic       rx_strobe, rx_parity_err, busy;
  logic       mon_en;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [10:0] bits;
    int          bad_low;
    int          gap;
  } frame_t;

  frame_t     obs_q[$];
  logic [7:0] exp_q[$];
  logic [8:0] rx_exp_q[$];

  always #5 clk_sys = ~clk_sys;

  ps2_device_port #(
    .PS2DIV   (Div),
    .FIFO_BITS(3)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .wr_data      (wr_data),
    .wr_strobe    (wr_strobe),
    .fifo_full    (fifo_full),
    .overflow     (overflow),
    .ps2_clk_out  (ps2_clk_out),
    .ps2_data_out (ps2_data_out),
    .ps2_clk_in   (host_clk),
    .ps2_data_in  (host_data),
    .rx_data      (rx_data),
    .rx_strobe    (rx_strobe),
    .rx_parity_err(rx_parity_err),
    .busy         (busy)
  );

  function automatic logic [10:0] frame_of(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  // Host-side frame monitor: data sampled at each falling clock edge.
  initial begin
    logic        prev;
    int          bit_cnt, low_cnt, high_cnt, bad_low, gap;
    logic [10:0] bits;
    prev = 1'b1; bit_cnt = 0; low_cnt = 0; high_cnt = 0; bad_low = 0; gap = 0; bits = '0;
    forever begin
      @(negedge clk_sys);
      if (reset || !mon_en) begin
        bit_cnt = 0; low_cnt = 0; high_cnt = 0;
        prev = ps2_clk_out;
      end else begin
        if (prev && !ps2_clk_out) begin
          if (bit_cnt == 0) begin gap = high_cnt; bad_low = 0; end
          if (bit_cnt < 11) bits[bit_cnt] = ps2_data_out;
          bit_cnt++;
          low_cnt = 0;
        end
        if (!prev && ps2_clk_out) begin
          if (low_cnt != int'(Div)) bad_low++;
          if (bit_cnt == 11) begin
            frame_t f;
            f.bits = bits; f.bad_low = bad_low; f.gap = gap;
            obs_q.push_back(f);
            bit_cnt = 0;
          end
        end
        if (ps2_clk_out) begin
          high_cnt++;
          if (high_cnt > 6) bit_cnt = 0;
        end else begin
          low_cnt++;
          high_cnt = 0;
        end
        prev = ps2_clk_out;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1);
  end

  task automatic write_byte(input logic [7:0] b, input bit expect_sent);
    @(negedge clk_sys);
    wr_data = b; wr_strobe = 1'b1;
    @(negedge clk_sys);
    wr_strobe = 1'b0;
    if (expect_sent) exp_q.push_back(b);
  endtask

  task automatic get_frame(output frame_t f, output bit got);
    got = 0; f.bits = '0; f.bad_low = 0; f.gap = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_sys); #1;
      if (obs_q.size() > 0) begin f = obs_q.pop_front(); got = 1; break; end
    end
  endtask

  task automatic wait_clk_out(input logic lvl, output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_sys);
      if (ps2_clk_out === lvl) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    n_checks++;
    if ({ps2_clk_out, ps2_data_out} !== 2'b11)
      $display("FAIL reset_lines: got %b required 11", {ps2_clk_out, ps2_data_out});
    else n_pass++;
    n_checks++;
    if ({fifo_full, overflow, rx_strobe, rx_parity_err, busy} !== 5'b0)
      $display("FAIL reset_flags: got %b required 00000",
               {fifo_full, overflow, rx_strobe, rx_parity_err, busy});
    else n_pass++;
    n_checks++;
    if (rx_data !== 8'h00 || dut.fifo_count !== '0)
      $display("FAIL reset_data: rx_data %h count %0d required 00 and 0", rx_data, dut.fifo_count);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_single();
    frame_t f; bit got; logic [7:0] e;
    write_byte(8'h1C, 1'b1);
    get_frame(f, got);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || f.bits !== 11'b100_0011_1000)
      $display("FAIL single_bits: got %b (seen %0d) required 10000111000", f.bits, got);
    else n_pass++;
    n_checks++;
    if (!got || f.bits !== frame_of(e))
      $display("FAIL single_sb: got %b required %b", f.bits, frame_of(e));
    else n_pass++;
    n_checks++;
    if (!got || f.bad_low != 0)
      $display("FAIL single_low_width: %0d low halves not %0d cycles", f.bad_low, Div);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || dut.fifo_count !== '0)
      $display("FAIL single_done: busy %b count %0d required 0 and 0", busy, dut.fifo_count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    frame_t f; bit got; logic [7:0] e;
    @(negedge clk_sys);
    wr_data = 8'h00; wr_strobe = 1'b1;
    @(negedge clk_sys);
    wr_data = 8'hFF;
    @(negedge clk_sys);
    wr_strobe = 1'b0;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    for (int k = 0; k < 2; k++) begin
      get_frame(f, got);
      e = exp_q.pop_front();
      n_checks++;
      if (!got || f.bits !== frame_of(e) || f.bits[9] !== 1'b1)
        $display("FAIL b2b_frame%0d: got %b required %b", k, f.bits, frame_of(e));
      else n_pass++;
      if (k == 1) begin
        n_checks++;
        if (!got || f.gap < 2 * int'(Div))
          $display("FAIL b2b_gap: got %0d high cycles required >= %0d", f.gap, 2 * Div);
        else n_pass++;
      end
    end
  endtask

  task automatic test_overflow();
    frame_t f; bit got; logic [7:0] e;
    host_clk = 1'b0;
    repeat (4) @(negedge clk_sys);
    for (int i = 0; i < 9; i++) begin
      write_byte(8'h30 + 8'(i), i < 8);
      if (i == 6) begin
        n_checks++;
        if (fifo_full !== 1'b0) $display("FAIL ovf_not_full7: got %b required 0", fifo_full);
        else n_pass++;
      end
      if (i == 7) begin
        n_checks++;
        if ({fifo_full, overflow} !== 2'b10)
          $display("FAIL ovf_full8: got %b required 10", {fifo_full, overflow});
        else n_pass++;
      end
      if (i == 8) begin
        n_checks++;
        if (overflow !== 1'b1) $display("FAIL ovf_sticky9: got %b required 1", overflow);
        else n_pass++;
      end
    end
    host_clk = 1'b1;
    for (int k = 0; k < 8; k++) begin
      get_frame(f, got);
      e = exp_q.pop_front();
      n_checks++;
      if (!got || f.bits !== frame_of(e))
        $display("FAIL ovf_drain%0d: got %b required %b", k, f.bits, frame_of(e));
      else n_pass++;
    end
    repeat (60) @(negedge clk_sys);
    n_checks++;
    if (obs_q.size() != 0 || busy !== 1'b0 || overflow !== 1'b1)
      $display("FAIL ovf_after: extra %0d busy %b overflow %b required 0 0 1",
               obs_q.size(), busy, overflow);
    else n_pass++;
  endtask

  task automatic test_inhibit();
    frame_t f; bit got, ok, all_ok; int low_seen; logic [7:0] e;
    all_ok = 1;
    write_byte(8'hAA, 1'b1);
    // Four fall/rise pairs land in the high half of frame bit 4 (data bit 3).
    for (int k = 0; k < 4; k++) begin
      wait_clk_out(1'b0, ok); all_ok &= ok;
      wait_clk_out(1'b1, ok); all_ok &= ok;
    end
    host_clk = 1'b0;
    repeat (3) @(negedge clk_sys);
    n_checks++;
    if (!all_ok || dut.state_q !== StInhibit)
      $display("FAIL inh_abort: state %0d (edges %0d) required %0d", dut.state_q, all_ok, StInhibit);
    else n_pass++;
    low_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_sys);
      if (ps2_clk_out !== 1'b1 || ps2_data_out !== 1'b1) low_seen++;
    end
    n_checks++;
    if (low_seen != 0 || dut.fifo_count !== 4'd1)
      $display("FAIL inh_hold: %0d driven cycles count %0d required 0 and 1",
               low_seen, dut.fifo_count);
    else n_pass++;
    host_clk = 1'b1;
    get_frame(f, got);
    e = exp_q.pop_front();
    n_checks++;
    if (!got || f.bits !== frame_of(e))
      $display("FAIL inh_retry: got %b required %b", f.bits, frame_of(e));
    else n_pass++;
  endtask

  task automatic test_rx();
    logic [9:0] bits; logic [8:0] e; bit ok; int ack_lo;
    mon_en = 1'b0;
    rx_exp_q.push_back({8'hFF, 1'b0});
    rx_exp_q.push_back({8'hFF, 1'b1});
    for (int t = 0; t < 2; t++) begin
      bits = {1'b1, (t == 0) ? 1'b1 : 1'b0, 8'hFF};
      @(negedge clk_sys);
      host_data = 1'b0;
      ok = 1; ack_lo = 0;
      for (int k = 0; k < 11 && ok; k++) begin
        wait_clk_out(1'b0, ok);
        if (!ok) break;
        host_data = (k < 10) ? bits[k] : 1'b1;
        if (k == 10) begin
          for (int i = 0; i < 20 && ps2_clk_out === 1'b0; i++) begin
            if (ps2_data_out === 1'b0) ack_lo++;
            @(negedge clk_sys);
          end
        end else begin
          wait_clk_out(1'b1, ok);
        end
      end
      n_checks++;
      if (!ok || ack_lo != int'(Div))
        $display("FAIL rx_ack%0d: ack low for %0d cycles (clock ok %0d) required %0d",
                 t, ack_lo, ok, Div);
      else n_pass++;
      for (int i = 0; i < 20 && rx_strobe !== 1'b1; i++) @(negedge clk_sys);
      e = rx_exp_q.pop_front();
      n_checks++;
      if (rx_strobe !== 1'b1 || {rx_data, rx_parity_err} !== e)
        $display("FAIL rx_byte%0d: strobe %b data %h perr %b required 1 %h %b",
                 t, rx_strobe, rx_data, rx_parity_err, e[8:1], e[0]);
      else n_pass++;
      @(negedge clk_sys);
      n_checks++;
      if (rx_strobe !== 1'b0) $display("FAIL rx_strobe_len%0d: got %b required 0", t, rx_strobe);
      else n_pass++;
      repeat (20) @(negedge clk_sys);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_reset_mid_tx();
    bit ok, all_ok;
    all_ok = 1;
    write_byte(8'h55, 1'b1);
    for (int k = 0; k < 5; k++) begin
      wait_clk_out(1'b0, ok); all_ok &= ok;
      wait_clk_out(1'b1, ok); all_ok &= ok;
    end
    wait_clk_out(1'b0, ok); all_ok &= ok;
    reset = 1'b1;
    @(posedge clk_sys); #1;
    n_checks++;
    if (!all_ok || {ps2_clk_out, ps2_data_out} !== 2'b11)
      $display("FAIL rst_mid_lines: got %b (edges %0d) required 11",
               {ps2_clk_out, ps2_data_out}, all_ok);
    else n_pass++;
    n_checks++;
    if (dut.fifo_count !== '0 || overflow !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_mid_state: count %0d overflow %b busy %b required 0 0 0",
               dut.fifo_count, overflow, busy);
    else n_pass++;
    @(negedge clk_sys);
    reset = 1'b0;
    void'(exp_q.pop_front());
    repeat (200) @(negedge clk_sys);
    n_checks++;
    if (obs_q.size() != 0) $display("FAIL rst_mid_discard: %0d frames required 0", obs_q.size());
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1; wr_data = '0; wr_strobe = 1'b0;
    host_clk = 1'b1; host_data = 1'b1; mon_en = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_inhibit();
    test_rx();
    test_reset_mid_tx();
    n_checks++;
    if (exp_q.size() != 0 || obs_q.size() != 0)
      $display("FAIL scoreboard_end: %0d expected, %0d observed left, required 0 0",
               exp_q.size(), obs_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_device_port.md
Name: ps2_device_port

Overview:
- Parametrised, bidirectional PS/2 device emulator: one instance per keyboard or mouse channel.
- Sits between the IO-controller SPI byte stream (clk_sys domain) and a core's PS/2 host logic.
- Generalises the fixed 8-byte, transmit-only PS/2 path:
  - FIFO depth and clock divider are parameters.
  - Bytes are popped only after a frame completes.
  - Host inhibit aborts and retries the frame.
  - Host-to-device command frames are received, parity-checked and acknowledged.

Parameters:
- PS2DIV, 100: clk_sys cycles per PS/2 half-period; must be >= 2.
- FIFO_BITS, 3: log2 of FIFO depth; depth = 2**FIFO_BITS entries.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_data  in  8  byte to send to the host.
- wr_strobe  in  1  one-cycle write into the FIFO.
- fifo_full  out  1  FIFO holds 2**FIFO_BITS bytes.
- overflow  out  1  sticky; set when a write is dropped; cleared only by reset.
- ps2_clk_out  out  1  device clock level; 1 = released.
- ps2_data_out  out  1  device data level; 1 = released.
- ps2_clk_in  in  1  host clock line level (asynchronous).
- ps2_data_in  in  1  host data line level (asynchronous).
- rx_data  out  8  last host command byte.
- rx_strobe  out  1  one-cycle pulse when rx_data is updated.
- rx_parity_err  out  1  valid with rx_strobe; 1 = odd-parity failure.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values:
  - ps2_clk_out = 1, ps2_data_out = 1.
  - FIFO empty: count = 0, pointers = 0.
  - fifo_full = 0, overflow = 0, rx_data = 0, rx_strobe = 0, rx_parity_err = 0, busy = 0.
  - Divider = 0, state = IDLE.
- Reset mid-frame: both lines released on the next cycle; the frame is discarded.
- Input synchronisation: ps2_clk_in and ps2_data_in pass through 2-flop synchronisers. All decisions use the synchronised values (2-cycle latency).
- Tick generator:
  - Counter 0..PS2DIV-1.
  - tick is a 1-cycle pulse when the counter == PS2DIV-1.
  - Phase toggles on each tick, giving a PS/2 clock period of 2*PS2DIV cycles.
  - The counter runs freely in all states.
- FIFO:
  - Count-based, so full and empty are unambiguous at any depth.
  - Write when wr_strobe and not full.
  - wr_strobe while full: byte dropped, overflow set.
  - Simultaneous write and pop while full: the pop occurs first and the write is accepted.
- TX frame: 11 bits in this order:
  - start bit 0;
  - data[0..7], LSB first;
  - odd parity (parity bit = ~^data);
  - stop bit 1.
- TX bit timing:
  - Data changes on a tick that makes ps2_clk_out go high.
  - ps2_clk_out goes low on the following tick.
  - The host samples on the falling edge.
- States:
  - IDLE:
    - On a tick with phase = high, FIFO non-empty and synced clk_in = 1: if synced data_in = 0 (host request-to-send), go to RX. Otherwise latch the head byte (no pop), drive the start bit and go to TX.
    - With the FIFO empty, data_in = 0 and clk_in = 1, go to RX.
  - TX:
    - Bit index 0..10.
    - After the low half of bit 10, pop the FIFO and go to IDLE with both lines released.
    - If synced clk_in = 0 while ps2_clk_out = 1 during bits 0..9: abort, release both lines, go to INHIBIT; the byte stays at the FIFO head.
    - Host inhibit during bit 10 is ignored; the frame counts as sent.
  - INHIBIT:
    - Wait until synced clk_in has been 1 for 2 consecutive ticks, then go to IDLE.
    - A pending retry restarts from the start bit.
  - RX:
    - Device generates 11 clock pulses.
    - Sample data_in on each tick that drives ps2_clk_out high (clock about to rise).
    - Bits sampled: 8 data LSB first, then parity, then stop.
    - On the 11th pulse, drive ps2_data_out = 0 (ack) for its low half.
    - Then release, go to IDLE, pulse rx_strobe, load rx_data, set rx_parity_err = ~(^{data, parity}).
    - A stop bit sampled as 0 still completes the frame; rx_parity_err reports parity only.
    - Host pulls clk_in low mid-RX: discard, no strobe, go to INHIBIT.
- ps2_clk_out and ps2_data_out are registered; no combinational path from inputs.

Decomposition:
- Shared package ps2_pkg:
  - state enum: IDLE, TX, RX, INHIBIT;
  - PS2_FRAME_BITS = 11;
  - function odd_parity(byte).
- One natural sub-module: ps2_fifo (parametrised by FIFO_BITS, providing count, full, empty, head, pop, push).
- Divider, synchronisers and state machine stay in the top.

Test Plan:
- PS2DIV=4, write 0x1C, host idle:
  - data_out sequence 0,0,0,1,1,1,0,0,0,0,1 (parity 0);
  - 11 low clock pulses of 4 cycles each;
  - FIFO empty and busy = 0 after the 11th pulse.
- Write 0x00 then 0xFF back-to-back: two frames, both with parity bit 1, separated by >= 1 idle half-period; order preserved.
- FIFO_BITS=3, 9 writes with the host holding clk_in low:
  - fifo_full = 1 after the 8th write;
  - 9th write dropped, overflow = 1;
  - releasing clk_in drains exactly 8 bytes.
- Host pulls clk_in low during data bit 3 of 0xAA:
  - lines released within 3 cycles, no pop;
  - after release, 0xAA is resent in full from the start bit.
- Host RTS, sends 0xFF with parity 1 and stop 1:
  - rx_data = 0xFF, rx_strobe one cycle, rx_parity_err = 0;
  - ps2_data_out = 0 during the 11th clock low.
  - Repeat with parity 0: rx_parity_err = 1.
- Assert reset mid-TX at bit 5: next cycle both outputs = 1, FIFO empty, overflow = 0.
